// File: rtl/core_pkg.sv
// Shared front-end definitions for the multicycle core: fetch FSM states,
// datapath width and instruction geometry.
package core_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DELIVER
    } fetch_state_t;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch initiator: reads one word at PC over req/gnt/rvalid,
// strobes it into the instruction register and advances PC.
module instr_fetch
    import core_pkg::*;
#(
    parameter int              XLEN           = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_start,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_next,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    output logic [31:0]     instruction,
    output logic            write_ir,
    output logic [XLEN-1:0] pc,
    output logic            busy,
    output logic            fetch_fault
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [31:0]      instr_q, instr_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  fetch_addr;
    logic             fetch_go;
    logic             fetch_misaligned;
    logic             timeout_hit;

    // A redirect in the same cycle as a fetch request steers that fetch.
    always_comb begin
        fetch_addr       = pc_load ? pc_next : pc_q;
        fetch_go         = fetch_start && !fault_q && word_aligned(fetch_addr[1:0]);
        fetch_misaligned = fetch_start && !fault_q && !word_aligned(fetch_addr[1:0]);
        timeout_hit      = !mem_rvalid && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_go) state_d = REQ;
            REQ:     if (mem_gnt) state_d = WAIT;
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = DELIVER;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d    = pc_next;
                    fault_d = 1'b0;
                end
                if (fetch_misaligned) fault_d = 1'b1;
                if (fetch_go)         addr_d  = fetch_addr;
            end
            REQ: begin
                if (mem_gnt) cnt_d = '0;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    instr_d = mem_rdata;
                    pc_d    = addr_q + XLEN'(INSTR_BYTES);
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            instr_q <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mem_req  = (state_q == REQ);
        write_ir = (state_q == DELIVER);
        busy     = (state_q != IDLE);
    end

    assign mem_addr    = addr_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized fetch transactions checked against a transaction-level PC/fault model.
module tb_instr_fetch;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start, pc_load, mem_gnt, mem_rvalid;
    logic [31:0] pc_next, mem_rdata;
    logic        mem_req, write_ir, busy, fetch_fault;
    logic [31:0] mem_addr, instruction, pc;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_fault;

    always #5 clk = ~clk;

    instr_fetch #(
        .XLEN(32),
        .RESET_PC(32'h0),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_start(fetch_start),
        .pc_load(pc_load),
        .pc_next(pc_next),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .instruction(instruction),
        .write_ir(write_ir),
        .pc(pc),
        .busy(busy),
        .fetch_fault(fetch_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One fetch request issued from IDLE; gd = cycles before grant, rd = WAIT
    // cycles before rvalid (rd >= TO means memory never answers).
    task automatic fetch(input logic ld, input logic [31:0] tgt, input int gd,
                         input int rd, input logic [31:0] data);
        logic        old_fault;
        logic [31:0] addr;
        bit          go;
        old_fault = m_fault;
        go        = 0;
        if (ld) begin
            m_pc    = tgt;
            m_fault = 1'b0;
        end
        addr = m_pc;
        if (!old_fault) begin
            if (addr % 4 != 0) m_fault = 1'b1;
            else               go      = 1;
        end

        pc_load     = ld;
        pc_next     = tgt;
        fetch_start = 1'b1;
        tick();
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        pc_next     = $urandom;

        if (!go) begin
            repeat (3) begin
                chk1("nofetch_req", mem_req, 1'b0);
                chk1("nofetch_busy", busy, 1'b0);
                tick();
            end
            chk1("nofetch_fault", fetch_fault, m_fault);
            chk("nofetch_pc", pc, m_pc);
            return;
        end

        for (int i = 0; i < gd; i++) begin
            chk1("req_hold", mem_req, 1'b1);
            chk("req_addr_stall", mem_addr, addr);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'($urandom);
            tick();
        end
        chk1("req_up", mem_req, 1'b1);
        chk("req_addr", mem_addr, addr);
        chk1("req_busy", busy, 1'b1);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'($urandom);
        tick();
        mem_gnt    = 1'b0;

        for (int k = 0; k < rd && k < TO; k++) begin
            chk1("wait_busy", busy, 1'b1);
            chk1("wait_req", mem_req, 1'b0);
            chk1("wait_wir", write_ir, 1'b0);
            chk1("wait_fault", fetch_fault, 1'b0);
            mem_rvalid = 1'b0;
            mem_gnt    = 1'($urandom);
            mem_rdata  = $urandom;
            tick();
        end
        mem_gnt = 1'b0;

        if (rd >= TO) begin
            m_fault = 1'b1;
            chk1("to_fault", fetch_fault, 1'b1);
            chk1("to_busy", busy, 1'b0);
            chk1("to_wir", write_ir, 1'b0);
            chk("to_pc", pc, m_pc);
            chk("to_instr", instruction, m_instr);
            return;
        end

        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        m_pc       = addr + 32'd4;
        m_instr    = data;
        chk1("dlv_wir", write_ir, 1'b1);
        chk("dlv_instr", instruction, m_instr);
        chk("dlv_pc", pc, m_pc);
        chk1("dlv_busy", busy, 1'b1);
        tick();
        chk1("post_wir", write_ir, 1'b0);
        chk1("post_busy", busy, 1'b0);
        chk("post_instr", instruction, m_instr);
    endtask

    task automatic load_only(input logic [31:0] tgt);
        pc_load = 1'b1;
        pc_next = tgt;
        tick();
        pc_load = 1'b0;
        m_pc    = tgt;
        m_fault = 1'b0;
        chk("load_pc", pc, m_pc);
        chk1("load_fault", fetch_fault, 1'b0);
        chk1("load_busy", busy, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_req"}, mem_req, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_wir"}, write_ir, 1'b0);
        chk1({tag, "_fault"}, fetch_fault, 1'b0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_instr"}, instruction, 32'h0);
    endtask

    initial begin
        logic [31:0] tgt;
        int          gd, rd;
        reset       = 1'b0;
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        pc_next     = '0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        m_pc        = 32'h0;
        m_instr     = 32'h0;
        m_fault     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Earliest handshake, then a stalled memory
        fetch(1'b0, 32'h0, 0, 0, 32'h00500093);
        chk("basic_pc4", pc, 32'h4);
        fetch(1'b0, 32'h0, 3, 5, 32'hA5A5_1234);

        // Redirect with simultaneous fetch
        fetch(1'b1, 32'h100, 0, 0, 32'h1111_2222);
        chk("redir_pc", pc, 32'h104);

        // Misaligned target faults; further fetches ignored until a redirect
        fetch(1'b1, 32'h102, 0, 0, 32'h0);
        chk1("mis_fault", fetch_fault, 1'b1);
        fetch(1'b0, 32'h0, 0, 0, 32'h0);
        fetch(1'b1, 32'h300, 0, 0, 32'h0);
        load_only(32'h200);
        fetch(1'b0, 32'h0, 1, 2, 32'hCAFE_F00D);

        // Memory never answers
        fetch(1'b0, 32'h0, 0, TO, 32'h0);
        load_only(32'h40);

        // PC wraps at the top of the address space
        fetch(1'b1, 32'hFFFF_FFFC, 1, 1, 32'h0BAD_CAFE);
        chk("wrap_pc", pc, 32'h0);

        // Reset while waiting for data; the late rvalid must be dropped
        pc_load     = 1'b1;
        pc_next     = 32'h80;
        fetch_start = 1'b1;
        tick();
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        mem_gnt     = 1'b1;
        tick();
        mem_gnt     = 1'b0;
        tick();
        chk1("midrst_busy_pre", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk1("late_wir", write_ir, 1'b0);
        chk1("late_busy", busy, 1'b0);
        chk("late_instr", instruction, 32'h0);
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_fault = 1'b0;
        tick();
        chk1("late_wir2", write_ir, 1'b0);

        for (int n = 0; n < 40; n++) begin
            tgt = $urandom;
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            gd = $urandom_range(0, 4);
            rd = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 5);
            if ($urandom_range(0, 5) == 0) begin
                tgt[1:0] = 2'b00;
                load_only(tgt);
            end else begin
                fetch(($urandom_range(0, 2) == 0), tgt, gd, rd, $urandom);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
